// File: rtl/led_rx_pkg.sv
// Shared constants for the UART receive / 7-segment display block:
// baud divider lookup, hex segment table, special glyphs, receiver states.
`timescale 1ns/1ps
package led_rx_pkg;

  localparam int unsigned SEG_W = 7;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_P     = 7'b0001100;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Clock cycles per 16x sample tick; never returns 0.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned baud;
    int unsigned div;
    case (sel)
      3'd0:    baud = 32'd300;
      3'd1:    baud = 32'd1200;
      3'd2:    baud = 32'd4800;
      3'd3:    baud = 32'd9600;
      3'd4:    baud = 32'd19200;
      3'd5:    baud = 32'd38400;
      3'd6:    baud = 32'd57600;
      default: baud = 32'd115200;
    endcase
    div = clk_hz / (32'd16 * baud);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  function automatic logic [SEG_W-1:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/led_rx_display_uart_rx_core.sv
// UART receiver core: RxD synchronizer, 16x sample tick, 8E1 frame FSM.
// Emits a one-cycle done strobe with perr/ferr qualifying the captured byte.
`timescale 1ns/1ps
module uart_rx_core
  import led_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       rx_en,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       done,
  output logic       perr,
  output logic       ferr
);

  logic        rxd_meta;
  logic        rxd_s;
  logic [2:0]  sel_q;
  logic [31:0] div_cnt;
  logic [31:0] div_lim;
  logic        tick;
  rx_state_t   state;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        perr_q;

  always_comb div_lim = baud_div(CLK_FREQ_HZ, sel_q) - 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Sample tick generator; restarts whenever the baud selection moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= 3'd0;
      div_cnt <= 32'd0;
      tick    <= 1'b0;
    end else if (baud_select != sel_q) begin
      sel_q   <= baud_select;
      div_cnt <= 32'd0;
      tick    <= 1'b0;
    end else if (div_cnt >= div_lim) begin
      div_cnt <= 32'd0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 32'd1;
      tick    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RX_IDLE;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      perr_q   <= 1'b0;
      done     <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      done <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      if (!rx_en) begin
        state    <= RX_IDLE;
        tick_cnt <= 4'd0;
      end else begin
        case (state)
          RX_IDLE: begin
            if (!rxd_s) begin
              state    <= RX_START;
              tick_cnt <= 4'd0;
            end
          end
          RX_START: begin
            if (tick) begin
              if (tick_cnt == 4'd7) begin
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
                state    <= rxd_s ? RX_IDLE : RX_DATA;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          RX_DATA: begin
            if (tick) begin
              if (tick_cnt == 4'd15) begin
                tick_cnt <= 4'd0;
                shift    <= {rxd_s, shift[7:1]};
                if (bit_cnt == 3'd7) state <= RX_PARITY;
                else bit_cnt <= bit_cnt + 3'd1;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          RX_PARITY: begin
            if (tick) begin
              if (tick_cnt == 4'd15) begin
                tick_cnt <= 4'd0;
                perr_q   <= (^shift) ^ rxd_s;
                state    <= RX_STOP;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          RX_STOP: begin
            if (tick) begin
              if (tick_cnt == 4'd15) begin
                tick_cnt <= 4'd0;
                done     <= 1'b1;
                perr     <= perr_q;
                ferr     <= ~rxd_s;
                state    <= RX_IDLE;
              end else begin
                tick_cnt <= tick_cnt + 4'd1;
              end
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  assign data = shift;

endmodule

// File: rtl/led_rx_display.sv
// UART receiver driving a 4-digit common-anode display (byte as hex on AN1/AN0).
// Define RX_ERR_DISPLAY_EN to show "PE"/"FE" after parity/framing errors.
`timescale 1ns/1ps
module led_rx_display
  import led_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50000000,
  parameter int unsigned REFRESH_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic       AN0,
  output logic       AN1,
  output logic       AN2,
  output logic       AN3,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp
);

  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [7:0]       rx_data;
  logic             rx_done;
  logic             rx_perr;
  logic             rx_ferr;
  logic [SEG_W-1:0] seg_hi;
  logic [SEG_W-1:0] seg_lo;
  logic             full;
  logic [RW-1:0]    refresh_cnt;
  logic [1:0]       digit_idx;
  logic             started;
  logic [SEG_W-1:0] seg_next;
  logic [SEG_W-1:0] seg_q;
  logic [3:0]       an_q;

  uart_rx_core #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .rx_en       (Rx_EN),
    .rxd         (RxD),
    .data        (rx_data),
    .done        (rx_done),
    .perr        (rx_perr),
    .ferr        (rx_ferr)
  );

  // Display register holds pre-decoded glyphs for the two active digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_hi <= SEG_BLANK;
      seg_lo <= SEG_BLANK;
      full   <= 1'b0;
    end else if (rx_done) begin
      if (!rx_perr && !rx_ferr) begin
        seg_hi <= hex_seg(rx_data[7:4]);
        seg_lo <= hex_seg(rx_data[3:0]);
        full   <= 1'b1;
      end
`ifdef RX_ERR_DISPLAY_EN
      else begin
        seg_hi <= rx_ferr ? SEG_F : SEG_P;
        seg_lo <= SEG_E;
        full   <= 1'b1;
      end
`endif
    end
  end

  // Refresh timer; the first period only arms the scan so AN0 lights first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      started     <= 1'b0;
    end else if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
      refresh_cnt <= '0;
      if (!started) started <= 1'b1;
      else digit_idx <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_comb begin
    seg_next = SEG_BLANK;
    if (full) begin
      case (digit_idx)
        2'd0:    seg_next = seg_lo;
        2'd1:    seg_next = seg_hi;
        default: seg_next = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= 4'hF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= started ? ~(4'b0001 << digit_idx) : 4'hF;
      seg_q <= seg_next;
    end
  end

  assign {AN3, AN2, AN1, AN0}   = an_q;
  assign {g, f, e, d, c, b, a}  = seg_q;
  assign dp                     = 1'b1;

endmodule

// File: tb/tb_led_rx_display.sv
// Self-checking bench for led_rx_display: serial frames in, scanned display out.
`timescale 1ns/1ps
module tb_led_rx_display;

  localparam int unsigned REFRESH = 16;
  localparam int          BIT_FAST = 8960;
  localparam int          BIT_576  = 17361;

  logic       clk;
  logic       reset;
  logic [2:0] baud_select;
  logic       rx_en;
  logic       rxd;
  logic       an0, an1, an2, an3;
  logic       sa, sb_, sc, sd, se, sf, sg, sdp;

  int checks;
  int errors;
  logic [6:0] m_hi;
  logic [6:0] m_lo;
  logic [13:0] sb[$];

  led_rx_display #(
    .CLK_FREQ_HZ    (50000000),
    .REFRESH_CYCLES (REFRESH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Rx_EN       (rx_en),
    .RxD         (rxd),
    .AN0         (an0),
    .AN1         (an1),
    .AN2         (an2),
    .AN3         (an3),
    .a           (sa),
    .b           (sb_),
    .c           (sc),
    .d           (sd),
    .e           (se),
    .f           (sf),
    .g           (sg),
    .dp          (sdp)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  // Drive one 8E1 frame; drop_after >= 0 releases Rx_EN after that data bit.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int bit_ns, input int drop_after);
    logic en_ok;
    logic good;
    en_ok = rx_en && (drop_after < 0);
    good  = stop && (((^data) ^ par) == 1'b0);
    if (en_ok) begin
      if (good) begin
        m_hi = seg_of(data[7:4]);
        m_lo = seg_of(data[3:0]);
      end
`ifdef RX_ERR_DISPLAY_EN
      else if (!stop) begin
        m_hi = 7'b0001110;
        m_lo = 7'b0000110;
      end else begin
        m_hi = 7'b0001100;
        m_lo = 7'b0000110;
      end
`endif
    end
    sb.push_back({m_hi, m_lo});
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      #(bit_ns);
      if (i == drop_after) rx_en = 1'b0;
    end
    rxd = par;
    #(bit_ns);
    rxd = stop;
    #(bit_ns);
    rxd = 1'b1;
    #(2 * bit_ns);
  endtask

  // Scan all four digits and compare against the next scoreboard entry.
  task automatic check_display(input string name);
    logic [13:0] want;
    logic [6:0]  obs [4];
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        any_seen;
    logic        an_bad;
    logic        dp_bad;
    int          lows;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    want = sb.pop_front();
    for (int k = 0; k < 4; k++) obs[k] = 7'bx;
    any_seen = 1'b0;
    an_bad   = 1'b0;
    dp_bad   = 1'b0;
    for (int cyc = 0; cyc < 12 * REFRESH; cyc++) begin
      @(negedge clk);
      an   = {an3, an2, an1, an0};
      seg  = {sg, sf, se, sd, sc, sb_, sa};
      lows = 0;
      for (int k = 0; k < 4; k++) if (an[k] === 1'b0) lows++;
      if (lows > 1 || (lows == 0 && any_seen)) an_bad = 1'b1;
      if (lows == 1) begin
        any_seen = 1'b1;
        for (int k = 0; k < 4; k++) if (an[k] === 1'b0) obs[k] = seg;
      end
      if (sdp !== 1'b1) dp_bad = 1'b1;
    end
    checks++;
    if (obs[0] !== want[6:0]) begin
      errors++;
      $display("FAIL %s AN0: got %b want %b", name, obs[0], want[6:0]);
    end
    checks++;
    if (obs[1] !== want[13:7]) begin
      errors++;
      $display("FAIL %s AN1: got %b want %b", name, obs[1], want[13:7]);
    end
    checks++;
    if (obs[2] !== 7'b1111111) begin
      errors++;
      $display("FAIL %s AN2: got %b want 1111111", name, obs[2]);
    end
    checks++;
    if (obs[3] !== 7'b1111111) begin
      errors++;
      $display("FAIL %s AN3: got %b want 1111111", name, obs[3]);
    end
    checks++;
    if (an_bad !== 1'b0 || any_seen !== 1'b1) begin
      errors++;
      $display("FAIL %s anode_onehot: bad=%b seen=%b want bad=0 seen=1", name, an_bad, any_seen);
    end
    checks++;
    if (dp_bad !== 1'b0) begin
      errors++;
      $display("FAIL %s dp: dp went low, want held 1", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #400;
    @(negedge clk);
    checks++;
    if ({an3, an2, an1, an0} !== 4'hF) begin
      errors++;
      $display("FAIL reset_an: got %b want 1111", {an3, an2, an1, an0});
    end
    checks++;
    if ({sg, sf, se, sd, sc, sb_, sa} !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_seg: got %b want 1111111", {sg, sf, se, sd, sc, sb_, sa});
    end
    checks++;
    if (sdp !== 1'b1) begin
      errors++;
      $display("FAIL reset_dp: got %b want 1", sdp);
    end
    reset = 1'b1;
    sb.push_back({m_hi, m_lo});
    check_display("idle_blank");
  endtask

  task automatic test_good_frames();
    send_frame(8'h94, 1'b1, 1'b1, BIT_FAST, -1);
    check_display("rx_0x94");
    send_frame(8'hA1, 1'b1, 1'b1, BIT_FAST, -1);
    check_display("rx_0xA1");
  endtask

  task automatic test_errors();
    send_frame(8'h94, 1'b0, 1'b1, BIT_FAST, -1);
    check_display("parity_err");
    send_frame(8'h94, 1'b1, 1'b0, BIT_FAST, -1);
    check_display("frame_err");
  endtask

  task automatic test_glitch();
    sb.push_back({m_hi, m_lo});
    rxd = 1'b0;
    #200;
    rxd = 1'b1;
    #(3 * BIT_FAST);
    check_display("false_start");
  endtask

  task automatic test_rx_enable();
    rx_en = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, BIT_FAST, -1);
    rx_en = 1'b1;
    check_display("rx_disabled");
    send_frame(8'h3C, 1'b0, 1'b1, BIT_FAST, 3);
    rx_en = 1'b1;
    check_display("rx_abort");
    send_frame(8'h5E, 1'b1, 1'b1, BIT_FAST, -1);
    check_display("after_abort_0x5E");
  endtask

  task automatic test_baud_57600();
    baud_select = 3'd6;
    #1000;
    send_frame(8'h0F, 1'b0, 1'b1, BIT_576, -1);
    check_display("baud57600_0x0F");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    m_hi        = 7'b1111111;
    m_lo        = 7'b1111111;
    baud_select = 3'd7;
    rx_en       = 1'b1;
    rxd         = 1'b1;
    reset       = 1'b0;
    test_reset();
    test_good_frames();
    test_errors();
    test_glitch();
    test_rx_enable();
    test_baud_57600();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
